// File: rtl/mux_sync_tx.sv
// Source-side four-phase handshake transmitter: holds one word, raises req, waits for a
// synchronized ack high then low, and flags protocol glitches and slow handshakes.
module mux_sync_tx #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic             clk_src,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic [WIDTH-1:0] data_out,
    output logic             req_out,
    input  logic             ack_async,
    output logic             done_out,
    output logic [15:0]      xfer_count,
    output logic             proto_err,
    output logic             timeout_err
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        ACK_LO = 2'd2
    } state_t;

    state_t                   r_state;
    logic [SYNC_STAGES-1:0]   r_sync;
    logic                     r_ack_prev;
    logic [WIDTH-1:0]         r_data;
    logic                     r_req;
    logic                     r_done;
    logic [CNT_W-1:0]         r_xfer_count;
    logic                     r_proto_err;
    logic                     r_timeout_err;
    logic [CNT_W-1:0]         r_phase;
    logic                     w_ack_s;
    logic                     w_phase_sat;

    assign w_ack_s     = r_sync[SYNC_STAGES-1];
    assign w_phase_sat = (r_phase == TIMEOUT_C);

    assign ready_out   = (r_state == IDLE);
    assign data_out    = r_data;
    assign req_out     = r_req;
    assign done_out    = r_done;
    assign xfer_count  = r_xfer_count;
    assign proto_err   = r_proto_err;
    assign timeout_err = r_timeout_err;

    // Ack synchronizer; the only consumer of ack_async.
    always_ff @(posedge clk_src) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], ack_async};
        end
    end

    always_ff @(posedge clk_src) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ack_prev    <= 1'b0;
            r_data        <= '0;
            r_req         <= 1'b0;
            r_done        <= 1'b0;
            r_xfer_count  <= '0;
            r_proto_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_phase       <= '0;
        end else begin
            r_done     <= 1'b0;
            r_ack_prev <= w_ack_s;
            case (r_state)
                IDLE: begin
                    if (w_ack_s) begin
                        r_proto_err <= 1'b1;
                    end
                    if (valid_in) begin
                        r_data  <= data_in;
                        r_req   <= 1'b1;
                        r_state <= REQ_HI;
                        r_phase <= '0;
                    end
                end
                REQ_HI: begin
                    // An ack that drops before we ever acted on it is a glitch.
                    if (r_ack_prev && !w_ack_s) begin
                        r_proto_err <= 1'b1;
                    end
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= ACK_LO;
                        r_phase <= '0;
                    end else if (!w_phase_sat) begin
                        r_phase <= r_phase + CNT_W'(1);
                        if (r_phase + CNT_W'(1) == TIMEOUT_C) begin
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                ACK_LO: begin
                    if (!w_ack_s) begin
                        r_state      <= IDLE;
                        r_done       <= 1'b1;
                        r_xfer_count <= r_xfer_count + CNT_W'(1);
                        r_phase      <= '0;
                    end else if (!w_phase_sat) begin
                        r_phase <= r_phase + CNT_W'(1);
                        if (r_phase + CNT_W'(1) == TIMEOUT_C) begin
                            r_timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_req   <= 1'b0;
                    r_phase <= '0;
                end
            endcase
        end
    end

endmodule
